// File: rtl/aes256_key_expansion.sv
// AES-256 key schedule, iterative: one 32-bit schedule word per clock.
// A 256-bit key is taken over a valid/ready handshake, expanded into the
// 60-word schedule w[0..59], and all 15 round keys are presented in parallel.
// Optional feature macro: AES_KEY_ZEROIZE_EN adds a key_zeroize input that
// wipes the schedule and returns the block to IDLE.
module aes256_key_expansion (
  input  logic            clk,
  input  logic            reset,
  input  logic [255:0]    key_in_tdata,
  input  logic            key_in_tvalid,
  output logic            key_in_tready,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic            key_zeroize,
`endif
  output logic [1919:0]   round_keys,
  output logic            round_keys_valid
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] w [60];
  logic [31:0] w_prev;
  logic [31:0] w_old;
  logic [31:0] t_word;
  logic [31:0] next_word;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254, zero maps to zero)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] inv;
    a = x;
    for (int i = 0; i < 6; i++) a = gf_mul(gf_mul(a, a), x);
    inv = gf_mul(a, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    logic [31:0] s;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = sbox(v[8*b +: 8]);
    return s;
  endfunction

  // Byte 0 is in the LSBs, so [b0,b1,b2,b3] -> [b1,b2,b3,b0].
  function automatic logic [31:0] rot_word(input logic [31:0] v);
    return {v[7:0], v[31:8]};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] i);
    logic [7:0] r;
    case (i)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Next schedule word from w[cnt-1] and w[cnt-8].
  always_comb begin
    w_prev = w[cnt - 6'd1];
    w_old  = w[cnt - 6'd8];
    case (cnt[2:0])
      3'd0:    t_word = sub_word(rot_word(w_prev)) ^ {24'h0, rcon(cnt[5:3])};
      3'd4:    t_word = sub_word(w_prev);
      default: t_word = w_prev;
    endcase
    next_word = w_old ^ t_word;
  end

  // Round keys are the flat word registers: w[4r+c] lands at [128r+32c].
  always_comb begin
    round_keys = '0;
    for (int i = 0; i < 60; i++) round_keys[32*i +: 32] = w[i];
  end

  // Control FSM and schedule storage; ready/valid are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 6'd0;
      round_keys_valid <= 1'b0;
      key_in_tready    <= 1'b0;
      for (int i = 0; i < 60; i++) w[i] <= 32'h0;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (key_zeroize) begin
      state            <= IDLE;
      cnt              <= 6'd0;
      round_keys_valid <= 1'b0;
      key_in_tready    <= 1'b1;
      for (int i = 0; i < 60; i++) w[i] <= 32'h0;
    end
`endif
    else begin
      case (state)
        IDLE, DONE: begin
          if (key_in_tvalid && key_in_tready) begin
            for (int i = 0; i < 8; i++) w[i] <= key_in_tdata[32*i +: 32];
            cnt              <= 6'd8;
            round_keys_valid <= 1'b0;
            key_in_tready    <= 1'b0;
            state            <= EXPAND;
          end else begin
            key_in_tready    <= 1'b1;
          end
        end
        EXPAND: begin
          w[cnt] <= next_word;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd59) begin
            state            <= DONE;
            round_keys_valid <= 1'b1;
            key_in_tready    <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          key_in_tready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/aes256_key_expansion.md
# aes256_key_expansion

Iterative AES-256 key schedule. Accepts a 256-bit cipher key over a valid/ready handshake and expands it into the 60-word schedule (FIPS-197), one 32-bit word per clock. It presents all 15 round keys in parallel to the pipelined encryption round stages: round key 0 feeds the initial AddRoundKey, round keys 1..14 feed rounds 1..14. It is the upstream producer of every `round_key` input in the encryption datapath.

## Interface
Parameters: none. The AES-256 sizes are fixed: Nk=8, Nr=14, 60 words.

Ports:
- `clk`  in  1  – the one clock. All logic is on its rising edge.
- `reset`  in  1  – synchronous, active-high reset.
- `key_in_tdata`  in  256  – cipher key. Byte k is at `[8k+:8]`; FIPS byte string order, byte 0 in the LSBs.
- `key_in_tvalid`  in  1  – key present.
- `key_in_tready`  out  1  – block can accept a key.
- `round_keys`  out  1920  – round key r at `[128r+:128]`, r=0..14. Word w[4r+c] is at `[128r+32c+:32]`, and byte b of a word is at `[8b+:8]`.
- `round_keys_valid`  out  1  – full schedule is stable and valid.
- `key_zeroize`  in  1  – exists only when `AES_KEY_ZEROIZE_EN` is defined.

## Operation
- Storage is 60 × 32-bit word registers w[0..59], plus a 6-bit word counter `cnt` and an FSM.
- **FSM states: IDLE, EXPAND, DONE.**
- `key_in_tready` = 1 in IDLE and DONE, and 0 in EXPAND.
- **Accept** (tvalid & tready, from IDLE or DONE):
  - w[0..7] ← key words; word n = bytes 4n..4n+3.
  - `cnt` ← 8.
  - `round_keys_valid` ← 0.
  - Next state is EXPAND.
- **EXPAND:** each cycle, w[cnt] ← w[cnt-8] ^ t, where t is derived from w[cnt-1]:
  - cnt%8==0: t = SubWord(RotWord(w[cnt-1])) ^ Rcon(cnt/8).
  - cnt%8==4: t = SubWord(w[cnt-1]).
  - Otherwise: t = w[cnt-1].
- **Word-level operations:**
  - RotWord maps bytes [b0,b1,b2,b3] → [b1,b2,b3,b0], i.e. `{w[7:0],w[31:8]}`.
  - SubWord applies the shared forward S-box function to each byte.
  - Rcon is XORed into byte 0 (`[7:0]`) only. Values for cnt/8 = 1..7: 01, 02, 04, 08, 10, 20, 40.
- **Counter and exit:** `cnt` increments each EXPAND cycle. The cycle that writes w[59] moves the FSM to DONE and sets `round_keys_valid` ← 1.
- **DONE:** registers hold. A new accept restarts expansion.
- `key_in_tvalid` in EXPAND is ignored, because tready=0. The upstream source holds the key.
- `round_keys` is driven straight from the word registers. Partial schedule contents are visible during EXPAND but are qualified invalid.

## Timing
- **Reset values:**
  - All w = 0, `cnt` = 0, state = IDLE.
  - `round_keys` = 0.
  - `round_keys_valid` = 0.
  - `key_in_tready` = 0 in the cycle that `reset` is high, and 1 from the first cycle after it is released.
- **Latency:** if the accept occurs at edge E, round key 0 and round key 1 are valid in the register output after E. Then:
  - w[8] is written at E+1.
  - w[59] is written at E+52.
  - `round_keys_valid` is high from E+52 onward.
  - Accept-to-valid latency is 52 cycles.
- **Throughput:** one key per 53 cycles at best. A back-to-back accept is possible in the first DONE cycle.
- **Accept in DONE:** `round_keys_valid` falls at the accepting edge, in the same edge as the w[0..7] load.
- **Reset mid-EXPAND:** the reset edge clears everything and returns to IDLE. No partial key survives, and `round_keys_valid` stays 0.
- **Priority:** reset > zeroize (if built) > accept.

## Configuration
- Macro: `AES_KEY_ZEROIZE_EN`.
- **Defined:**
  - Input port `key_zeroize` is present.
  - A 1-cycle high pulse, in any state, clears all w and `cnt` to 0.
  - The FSM goes to IDLE and `round_keys_valid` goes to 0 at that edge.
  - A key offered in the same cycle is not accepted.
- **Undefined:** the port is absent, and the schedule is retained until reset or the next accepted key.

## Test plan
- **Reset:** assert `reset` 3 cycles, release → `round_keys`=0, `round_keys_valid`=0, `key_in_tready`=1 from the first cycle after release.
- **FIPS-197 A.3:** key 603deb10…0914dff4 → w[8]=9ba35411 and w[59]=706c631e (FIPS word order), valid exactly 52 cycles after accept.
- **FIPS-197 C.3:** key 000102…1f → the following round keys, then hold for 100 cycles with no change:
  - rk1 = 101112…1f.
  - rk2 = a573c29fa176c498a97fce93a572c09c.
  - rk14 = 24fc79ccbf0979e9371ac23c6d68de36.
- **Back-to-back keys:** hold `key_in_tvalid` with a second key during EXPAND → tready=0 for 52 cycles. The second key is accepted in the first DONE cycle, valid drops at that edge, and the second schedule is correct 52 cycles later.
- **Reset mid-operation:** assert `reset` at cycle 20 of EXPAND → all outputs 0 and IDLE. A fresh key afterwards expands correctly.
- **Zeroize (`AES_KEY_ZEROIZE_EN`):** pulse `key_zeroize` in DONE with a concurrent tvalid → `round_keys`=0, valid=0, key not accepted. The next key is accepted normally.
